// File: rtl/bg_tile_fetch.sv
// Background / window tile fetch sequencer for the DMG PPU.
// Walks map -> low bitplane -> high bitplane reads for each 8-pixel tile
// during mode 3, then offers the bitplanes to the BG pixel FIFO.
// A window match restarts fetching from the window map at column 0 and
// the window line counter advances at the end of every line that used it.
module bg_tile_fetch (
    input  logic        clk2,
    input  logic        reset_video2,
    input  logic        line_start,
    input  logic        line_end,
    input  logic        frame_start,
    input  logic        win_trigger,
    input  logic        ff40_d3,
    input  logic        ff40_d4,
    input  logic        ff40_d6,
    input  logic [7:0]  scx,
    input  logic [7:0]  scy,
    input  logic [7:0]  ly,
    input  logic [7:0]  md,
    output logic [12:0] vram_addr,
    output logic        vram_rd,
    input  logic        fifo_ready,
    output logic        tile_valid,
    output logic [7:0]  tile_lo,
    output logic [7:0]  tile_hi,
    output logic        win_mode
);

    // Sequencer states; *_A issue a read, *_B wait for md.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MAP_A = 3'd1;
    localparam logic [2:0] S_MAP_B = 3'd2;
    localparam logic [2:0] S_LO_A  = 3'd3;
    localparam logic [2:0] S_LO_B  = 3'd4;
    localparam logic [2:0] S_HI_A  = 3'd5;
    localparam logic [2:0] S_HI_B  = 3'd6;
    localparam logic [2:0] S_PUSH  = 3'd7;

    logic [2:0]  state_q,     state_d;
    logic [4:0]  tile_x_q,    tile_x_d;
    logic        win_mode_q,  win_mode_d;
    logic [7:0]  win_line_q,  win_line_d;
    logic [7:0]  tile_idx_q,  tile_idx_d;
    logic [7:0]  tile_lo_q,   tile_lo_d;
    logic [7:0]  tile_hi_q,   tile_hi_d;
    logic [12:0] vram_addr_q, vram_addr_d;
    logic        vram_rd_q,   vram_rd_d;

    logic        win_hit;
    logic        accept;
    logic [7:0]  bg_line;
    logic [4:0]  bg_col;
    logic [2:0]  row;
    logic [12:0] map_addr;
    logic [11:0] data_base;

    // A window match only counts once per line and only while fetching.
    assign win_hit    = win_trigger & ~win_mode_q & (state_q != S_IDLE);
    // A restart in the PUSH cycle withdraws the tile so it is never accepted.
    assign tile_valid = (state_q == S_PUSH) & ~win_hit;
    assign accept     = tile_valid & fifo_ready;

    assign vram_addr  = vram_addr_q;
    assign vram_rd    = vram_rd_q;
    assign tile_lo    = tile_lo_q;
    assign tile_hi    = tile_hi_q;
    assign win_mode   = win_mode_q;

    // Next-state, column, window and captured-byte logic.
    always_comb begin
        state_d    = state_q;
        tile_x_d   = tile_x_q;
        win_mode_d = win_mode_q;
        win_line_d = win_line_q;
        tile_idx_d = tile_idx_q;
        tile_lo_d  = tile_lo_q;
        tile_hi_d  = tile_hi_q;

        // md belongs to the read issued in the preceding *_A cycle.
        case (state_q)
            S_MAP_B: tile_idx_d = md;
            S_LO_B:  tile_lo_d  = md;
            S_HI_B:  tile_hi_d  = md;
            default: ;
        endcase

        if (line_end) begin
            state_d    = S_IDLE;
            win_mode_d = 1'b0;
            if (win_mode_q)
                win_line_d = win_line_q + 8'd1;
        end else if (win_hit) begin
            state_d    = S_MAP_A;
            win_mode_d = 1'b1;
            tile_x_d   = 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (line_start) begin
                        state_d    = S_MAP_A;
                        tile_x_d   = 5'd0;
                        win_mode_d = 1'b0;
                    end
                end
                S_MAP_A: state_d = S_MAP_B;
                S_MAP_B: state_d = S_LO_A;
                S_LO_A:  state_d = S_LO_B;
                S_LO_B:  state_d = S_HI_A;
                S_HI_A:  state_d = S_HI_B;
                S_HI_B:  state_d = S_PUSH;
                S_PUSH: begin
                    if (accept) begin
                        state_d  = S_MAP_A;
                        tile_x_d = tile_x_q + 5'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Frame start wins over a same-cycle end-of-line increment.
        if (frame_start)
            win_line_d = 8'd0;
    end

    // Address for the state being entered, so it is on the bus from that
    // state's first cycle (including the cycle right after a window match).
    always_comb begin
        bg_line   = scy + ly;
        bg_col    = scx[7:3] + tile_x_d;
        row       = win_mode_d ? win_line_q[2:0] : bg_line[2:0];
        map_addr  = win_mode_d ? {2'b11, ff40_d6, win_line_q[7:3], tile_x_d}
                               : {2'b11, ff40_d3, bg_line[7:3], bg_col};
        // Signed mode places indices 0x00-0x7F at 0x1000 and 0x80-0xFF at 0x0800.
        data_base = {~(ff40_d4 | tile_idx_d[7]), tile_idx_d, row};

        vram_addr_d = vram_addr_q;
        vram_rd_d   = 1'b0;
        case (state_d)
            S_MAP_A: begin
                vram_addr_d = map_addr;
                vram_rd_d   = 1'b1;
            end
            S_LO_A: begin
                vram_addr_d = {data_base, 1'b0};
                vram_rd_d   = 1'b1;
            end
            S_HI_A: begin
                vram_addr_d = {data_base, 1'b1};
                vram_rd_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk2 or posedge reset_video2) begin
        if (reset_video2) begin
            state_q     <= S_IDLE;
            tile_x_q    <= 5'd0;
            win_mode_q  <= 1'b0;
            win_line_q  <= 8'd0;
            tile_idx_q  <= 8'd0;
            tile_lo_q   <= 8'd0;
            tile_hi_q   <= 8'd0;
            vram_addr_q <= 13'd0;
            vram_rd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tile_x_q    <= tile_x_d;
            win_mode_q  <= win_mode_d;
            win_line_q  <= win_line_d;
            tile_idx_q  <= tile_idx_d;
            tile_lo_q   <= tile_lo_d;
            tile_hi_q   <= tile_hi_d;
            vram_addr_q <= vram_addr_d;
            vram_rd_q   <= vram_rd_d;
        end
    end

endmodule

// File: tb/tb_bg_tile_fetch.sv
// Scoreboard bench for bg_tile_fetch: a VRAM model answers reads, the
// stimulus pushes expected tiles, and a monitor checks every accepted tile.
module tb_bg_tile_fetch;
    logic        clk2 = 1'b0;
    logic        reset_video2 = 1'b1;
    logic        line_start = 1'b0, line_end = 1'b0, frame_start = 1'b0, win_trigger = 1'b0;
    logic        ff40_d3 = 1'b0, ff40_d4 = 1'b1, ff40_d6 = 1'b0;
    logic [7:0]  scx = 8'd0, scy = 8'd0, ly = 8'd0, md = 8'd0;
    logic [12:0] vram_addr;
    logic        vram_rd, fifo_ready = 1'b0, tile_valid, win_mode;
    logic [7:0]  tile_lo, tile_hi;

    bg_tile_fetch dut (
        .clk2(clk2), .reset_video2(reset_video2), .line_start(line_start),
        .line_end(line_end), .frame_start(frame_start), .win_trigger(win_trigger),
        .ff40_d3(ff40_d3), .ff40_d4(ff40_d4), .ff40_d6(ff40_d6),
        .scx(scx), .scy(scy), .ly(ly), .md(md),
        .vram_addr(vram_addr), .vram_rd(vram_rd), .fifo_ready(fifo_ready),
        .tile_valid(tile_valid), .tile_lo(tile_lo), .tile_hi(tile_hi),
        .win_mode(win_mode)
    );

    always #5 clk2 = ~clk2;

    typedef struct {
        logic [12:0] ma, la, ha;
        logic [7:0]  lo, hi;
        logic        wm;
    } exp_t;

    logic [7:0] mem [0:8191];
    exp_t       exp_q [$];
    int         errors = 0, checks = 0;
    int         cyc = 0, acc_cnt = 0, last_acc = 0, prev_acc = 0;
    logic [7:0] wl_m = 8'd0;
    bit         rand_rdy = 1'b0, fix_rdy = 1'b1;

    // VRAM: data for a read appears in the cycle after the strobe.
    always @(posedge clk2) md <= vram_rd ? mem[vram_addr] : 8'($urandom);
    always @(posedge clk2) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference: tile fields straight from the map/tile addressing rules.
    function automatic exp_t mk(bit wm, int tx);
        exp_t e;
        int line, row, idx, base;
        line = (int'(scy) + int'(ly)) % 256;
        if (wm) begin
            e.ma = 13'(32'h1800 + (int'(ff40_d6) << 10) + ((int'(wl_m) / 8) << 5) + tx);
            row  = int'(wl_m) % 8;
        end else begin
            e.ma = 13'(32'h1800 + (int'(ff40_d3) << 10) + ((line / 8) << 5)
                       + ((int'(scx) / 8 + tx) % 32));
            row  = line % 8;
        end
        idx  = int'(mem[e.ma]);
        base = ff40_d4 ? idx * 16 : 4096 + ((idx >= 128) ? idx - 256 : idx) * 16;
        e.la = 13'(base + row * 2);
        e.ha = 13'(base + row * 2 + 1);
        e.lo = mem[e.la];
        e.hi = mem[e.ha];
        e.wm = wm;
        return e;
    endfunction

    function automatic exp_t rec(int ma, int la, int ha, bit wm);
        exp_t e;
        e.ma = 13'(ma); e.la = 13'(la); e.ha = 13'(ha);
        e.lo = mem[e.la]; e.hi = mem[e.ha]; e.wm = wm;
        return e;
    endfunction

    // Monitor: tracks the last three reads and scores each accepted tile.
    logic [12:0] r0, r1, r2;
    bit          prev_stall;
    logic [7:0]  s_lo, s_hi;
    always @(negedge clk2) begin
        if (reset_video2) begin
            r0 = '0; r1 = '0; r2 = '0; prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_no_read", 32'(vram_rd), 0);
                chk("stall_lo", 32'(tile_lo), 32'(s_lo));
                chk("stall_hi", 32'(tile_hi), 32'(s_hi));
                chk("stall_valid", 32'(tile_valid | win_trigger), 1);
            end
            if (vram_rd) begin
                r2 = r1; r1 = r0; r0 = vram_addr;
            end
            if (tile_valid && fifo_ready) begin
                acc_cnt++;
                prev_acc = last_acc;
                last_acc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_tile", 32'(tile_lo), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("map_addr", 32'(r2), 32'(e.ma));
                    chk("lo_addr",  32'(r1), 32'(e.la));
                    chk("hi_addr",  32'(r0), 32'(e.ha));
                    chk("tile_lo",  32'(tile_lo), 32'(e.lo));
                    chk("tile_hi",  32'(tile_hi), 32'(e.hi));
                    chk("win_mode", 32'(win_mode), 32'(e.wm));
                end
            end
            prev_stall = tile_valid & ~fifo_ready & ~line_end & ~win_trigger;
            s_lo = tile_lo;
            s_hi = tile_hi;
        end
    end

    task automatic tick();
        @(posedge clk2);
        #1;
        if (rand_rdy) fifo_ready = ($urandom_range(0, 3) != 0);
        else          fifo_ready = fix_rdy;
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 400) begin
            tick();
            n++;
        end
        if (acc_cnt < target) chk("accept_timeout", 32'(acc_cnt), 32'(target));
    endtask

    int ls_cyc;
    task automatic start_line();
        ls_cyc = cyc;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic end_line(input bit fs, input bit had_win);
        line_end = 1'b1;
        frame_start = fs;
        tick();
        line_end = 1'b0;
        frame_start = 1'b0;
        if (had_win) wl_m = wl_m + 8'd1;
        if (fs) wl_m = 8'd0;
        chk("win_mode_cleared", 32'(win_mode), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);
        tick();
    endtask

    task automatic trigger();
        win_trigger = 1'b1;
        tick();
        win_trigger = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, n;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);

        // Reset state
        repeat (3) tick();
        chk("rst_addr", 32'(vram_addr), 0);
        chk("rst_rd", 32'(vram_rd), 0);
        chk("rst_valid", 32'(tile_valid), 0);
        chk("rst_lo", 32'(tile_lo), 0);
        chk("rst_hi", 32'(tile_hi), 0);
        chk("rst_win", 32'(win_mode), 0);
        reset_video2 = 1'b0;
        repeat (2) tick();

        // Basic BG fetch, latency and 7-cycle cadence
        mem[13'h1800] = 8'h05; mem[13'h0050] = 8'hAA; mem[13'h0051] = 8'h55;
        mem[13'h1801] = 8'h09;
        exp_q.push_back(rec('h1800, 'h0050, 'h0051, 0));
        exp_q.push_back(rec('h1801, 'h0090, 'h0091, 0));
        base = acc_cnt;
        start_line();
        n = 0;
        while (!tile_valid && n < 20) begin tick(); n++; end
        chk("first_lo", 32'(tile_lo), 32'h AA);
        chk("first_hi", 32'(tile_hi), 32'h55);
        chk("latency", 32'(cyc - ls_cyc), 7);
        wait_acc(base + 2);
        chk("cadence", 32'(last_acc - prev_acc), 7);
        end_line(0, 0);

        // Signed tile data addressing, row 3
        ff40_d4 = 1'b0; ly = 8'd3;
        mem[13'h1800] = 8'h80; mem[13'h1801] = 8'h7F;
        exp_q.push_back(rec('h1800, 'h0806, 'h0807, 0));
        exp_q.push_back(rec('h1801, 'h17F6, 'h17F7, 0));
        base = acc_cnt;
        start_line();
        wait_acc(base + 2);
        end_line(0, 0);

        // Column wrap from scx=0xF8
        ff40_d4 = 1'b1; ly = 8'd0; scx = 8'hF8;
        mem[13'h181F] = 8'h12; mem[13'h1800] = 8'h34;
        exp_q.push_back(rec('h181F, 'h0120, 'h0121, 0));
        exp_q.push_back(rec('h1800, 'h0340, 'h0341, 0));
        base = acc_cnt;
        start_line();
        wait_acc(base + 2);
        end_line(0, 0);

        // Stall in PUSH for 5 cycles, then accept
        scx = 8'd0; fix_rdy = 1'b0; fifo_ready = 1'b0;
        exp_q.push_back(mk(0, 0));
        exp_q.push_back(mk(0, 1));
        base = acc_cnt;
        start_line();
        n = 0;
        while (!tile_valid && n < 20) begin tick(); n++; end
        chk("stall_entry_valid", 32'(tile_valid), 1);
        repeat (5) tick();
        chk("stall_held_valid", 32'(tile_valid), 1);
        fix_rdy = 1'b1; fifo_ready = 1'b1;
        tick();
        chk("post_accept_rd", 32'(vram_rd), 1);
        chk("post_accept_addr", 32'(vram_addr), 32'h1801);
        wait_acc(base + 2);
        end_line(0, 0);

        // Window: preload win_line to 10 with ten window lines
        ff40_d6 = 1'b1;
        repeat (10) begin
            start_line();
            trigger();
            end_line(0, 1);
        end
        mem[13'h1C20] = 8'h21; mem[13'h1C00] = 8'h22;
        // Trigger during HI_A
        exp_q.push_back(rec('h1C20, 'h0214, 'h0215, 1));
        base = acc_cnt;
        start_line();
        repeat (4) tick();
        trigger();
        chk("win_map_addr", 32'(vram_addr), 32'h1C20);
        chk("win_map_rd", 32'(vram_rd), 1);
        chk("win_mode_set", 32'(win_mode), 1);
        wait_acc(base + 1);
        end_line(0, 1);
        // Trigger during PUSH with the FIFO ready: BG tile must not be taken
        exp_q.push_back(rec('h1C20, 'h0216, 'h0217, 1));
        base = acc_cnt;
        start_line();
        repeat (6) tick();
        win_trigger = 1'b1;
        #1;
        chk("push_trig_masks_valid", 32'(tile_valid), 0);
        tick();
        win_trigger = 1'b0;
        chk("push_trig_restart_rd", 32'(vram_rd), 1);
        chk("push_trig_win_addr", 32'(vram_addr), 32'h1C20);
        wait_acc(base + 1);
        end_line(1, 1);
        // frame_start with line_end cleared the window line
        exp_q.push_back(rec('h1C00, 'h0220, 'h0221, 1));
        base = acc_cnt;
        start_line();
        trigger();
        wait_acc(base + 1);
        end_line(0, 1);

        // Asynchronous reset during LO_B
        start_line();
        repeat (3) tick();
        #2 reset_video2 = 1'b1;
        #1;
        chk("async_rst_addr", 32'(vram_addr), 0);
        chk("async_rst_rd", 32'(vram_rd), 0);
        chk("async_rst_valid", 32'(tile_valid), 0);
        chk("async_rst_lo", 32'(tile_lo), 0);
        chk("async_rst_hi", 32'(tile_hi), 0);
        chk("async_rst_win", 32'(win_mode), 0);
        tick(); tick();
        reset_video2 = 1'b0;
        wl_m = 8'd0;
        exp_q.delete();
        n = 0;
        repeat (6) begin tick(); n += int'(vram_rd) + int'(tile_valid); end
        chk("idle_after_reset", 32'(n), 0);

        // Randomized lines, BG and window, random FIFO backpressure
        rand_rdy = 1'b1;
        for (int ln = 0; ln < 40; ln++) begin
            bit wn, ign, fs;
            int j, l, k;
            scx = 8'($urandom); scy = 8'($urandom); ly = 8'($urandom);
            ff40_d3 = 1'($urandom); ff40_d4 = 1'($urandom); ff40_d6 = 1'($urandom);
            wn  = 1'($urandom);
            ign = 1'($urandom);
            fs  = ($urandom_range(0, 4) == 0);
            j = $urandom_range(0, 2);
            l = $urandom_range(1, 3);
            k = $urandom_range(1, 4);
            if (wn) begin
                for (int t = 0; t < j; t++) exp_q.push_back(mk(0, t));
                for (int t = 0; t < l; t++) exp_q.push_back(mk(1, t));
            end else begin
                for (int t = 0; t < k; t++) exp_q.push_back(mk(0, t));
            end
            base = acc_cnt;
            start_line();
            if (wn) begin
                wait_acc(base + j);
                repeat ($urandom_range(0, 6)) tick();
                trigger();
                if (ign) begin
                    repeat ($urandom_range(0, 3)) tick();
                    trigger();
                end
                wait_acc(base + j + l);
            end else begin
                wait_acc(base + k);
            end
            repeat ($urandom_range(0, 5)) tick();
            end_line(fs, wn);
        end
        rand_rdy = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
